peg_move_sequencer: RTL and testbench
=====================================

// Module: peg_move_sequencer
// PURPOSE
// Upstream driver for the 5x5 peg-jump board model. Drives its from/dir move
// inputs and reads back its combinational peg count cnt.
// Greedy first-found search: scans candidate moves in fixed order (from 0..24,
// dir 0..3) and detects an accepted move by a drop in cnt.
// After each accepted move it restarts the scan at candidate 0.
// Reports SOLVED when cnt reaches TARGET_CNT, and STUCK after a full sweep with
// no accepted move.
// PARAMETERS
// TARGET_CNT  1    peg count that declares the puzzle solved
// NUM_CAND    100  candidates per full sweep (25 holes x 4 directions)
// IDLE_FROM   31   'from' value driven when no move is offered (>=25, so the board ignores it)
// PORTS
// clk        in   1  clock; all state changes on posedge
// rst        in   1  synchronous, active-high reset
// start      in   1  one-cycle pulse, begins a search from IDLE
// cnt        in   5  peg count from the board model (reflects board after last edge)
// from       out  5  candidate start hole, registered
// dir        out  2  candidate direction, registered: U=0 D=1 L=2 R=3
// move_valid out  1  one-cycle pulse: the candidate on last_from/last_dir was accepted
// last_from  out  5  start hole of the most recent accepted move
// last_dir   out  2  direction of the most recent accepted move
// move_cnt   out  5  accepted moves since start (saturates at 31)
// busy       out  1  high in ISSUE/CHECK
// solved     out  1  high in SOLVED
// stuck      out  1  high in STUCK
// err        out  1  sticky; cnt changed by anything other than 0 or -1 after a move
// BEHAVIOUR
// Reset values: from=IDLE_FROM, dir=0, move_valid=0, last_from=0, last_dir=0,
//   move_cnt=0, busy=0, solved=0, stuck=0, err=0, state=IDLE.
// rst dominates start and is honoured in every state, including mid-search.
// Registers: cand_idx[6:0] (0..99), miss_cnt[6:0], prev_cnt[4:0].
//   from = cand_idx>>2; dir = cand_idx[1:0].
// IDLE
//   start=1 -> if cnt<=TARGET_CNT go SOLVED, else go ISSUE with cand_idx=0, miss_cnt=0.
//   start=0 -> stay; start pulses in any other state are ignored.
// ISSUE (1 cycle)
//   Drive from/dir for cand_idx.
//   At the posedge leaving ISSUE: the board samples the move; prev_cnt<=cnt; go CHECK.
// CHECK (1 cycle)
//   Drive from=IDLE_FROM so no second move occurs.
//   Compare cnt against prev_cnt at the posedge leaving CHECK:
//   cnt==prev_cnt-1 (accepted)
//     move_valid=1 next cycle; last_from/last_dir <= candidate; move_cnt++.
//     cand_idx<=0; miss_cnt<=0.
//     If cnt==TARGET_CNT go SOLVED, else go ISSUE.
//   cnt==prev_cnt (rejected)
//     miss_cnt++; cand_idx <= (cand_idx==NUM_CAND-1) ? 0 : cand_idx+1.
//     If miss_cnt+1==NUM_CAND go STUCK, else go ISSUE.
//   any other cnt
//     err<=1; go STUCK.
// SOLVED / STUCK
//   Terminal; from=IDLE_FROM. Exit only via rst.
// Timing
//   2 cycles per candidate; an accepted move is visible on move_valid 2 cycles
//   after its ISSUE cycle.
//   A full fruitless sweep takes 200 cycles from the last accept (or from start) to stuck=1.
// Width rules
//   move_cnt saturates at 31 (never wraps).
//   miss_cnt never exceeds NUM_CAND.
// TESTING
// T1 Real board, initial 23 pegs (holes 12 and 24 empty), start.
//    -> Candidates 0..7 are rejected; first move_valid after 18 cycles
//       with last_from=2, last_dir=0 (U); move_cnt=1; cnt=22.
// T2 Stub cnt held at 5, start.
//    -> No move_valid; stuck=1 exactly 200 cycles after the ISSUE state is
//       entered; busy=0; err=0.
// T3 Stub cnt = 3 that decrements on every 3rd ISSUE.
//    -> move_valid x2; solved=1 once cnt=1; move_cnt=2; from=31 thereafter.
// T4 Stub cnt that drops 10->8 after one ISSUE.
//    -> err=1 and stuck=1 at the end of that CHECK; err stays high until rst.
// T5 Assert rst in a CHECK cycle mid-search (move_cnt=4).
//    -> Next cycle all outputs at reset values; a later start restarts at cand_idx=0.
// T6 start with cnt=1 already.
//    -> solved=1 on the next cycle; from never leaves 31; move_cnt=0.

Source files
------------

// File: rtl/peg_move_sequencer_if.sv
// Move/handshake bundle between the peg move sequencer and its environment.
// master = sequencer side, slave = board/controller side.
interface peg_move_sequencer_if;
  logic       start;
  logic [4:0] cnt;
  logic [4:0] from;
  logic [1:0] dir;
  logic       move_valid;
  logic [4:0] last_from;
  logic [1:0] last_dir;
  logic [4:0] move_cnt;
  logic       busy;
  logic       solved;
  logic       stuck;
  logic       err;

  modport master (
    input  start, cnt,
    output from, dir, move_valid, last_from, last_dir, move_cnt,
           busy, solved, stuck, err
  );

  modport slave (
    output start, cnt,
    input  from, dir, move_valid, last_from, last_dir, move_cnt,
           busy, solved, stuck, err
  );
endinterface

// File: rtl/peg_move_sequencer.sv
// Greedy first-found move search for a 5x5 peg-jump board model; a candidate
// counts as accepted when the board's peg count drops by exactly one.
module peg_move_sequencer #(
  parameter logic [4:0] TARGET_CNT = 5'd1,
  parameter logic [6:0] NUM_CAND   = 7'd100,
  parameter logic [4:0] IDLE_FROM  = 5'd31
) (
  input logic                  clk,
  input logic                  rst,
  peg_move_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    CHECK  = 3'd2,
    SOLVED = 3'd3,
    STUCK  = 3'd4
  } state_t;

  state_t     state_r, state_s;
  logic [6:0] cand_idx_r, cand_idx_s;
  logic [6:0] miss_cnt_r, miss_cnt_s;
  logic [4:0] prev_cnt_r, prev_cnt_s;
  logic [4:0] from_r, from_s;
  logic [1:0] dir_r, dir_s;
  logic       move_valid_r, move_valid_s;
  logic [4:0] last_from_r, last_from_s;
  logic [1:0] last_dir_r, last_dir_s;
  logic [4:0] move_cnt_r, move_cnt_s;
  logic       busy_r, busy_s;
  logic       solved_r, solved_s;
  logic       stuck_r, stuck_s;
  logic       err_r, err_s;
  logic       accept_s;
  logic       reject_s;

  // Widened so prev_cnt=0 cannot alias to an accepted count of 31.
  assign accept_s = (({1'b0, bus.cnt} + 6'd1) == {1'b0, prev_cnt_r});
  assign reject_s = (bus.cnt == prev_cnt_r);

  // Next-state, search bookkeeping and next values of every registered output.
  always_comb begin
    state_s      = state_r;
    cand_idx_s   = cand_idx_r;
    miss_cnt_s   = miss_cnt_r;
    prev_cnt_s   = prev_cnt_r;
    move_valid_s = 1'b0;
    last_from_s  = last_from_r;
    last_dir_s   = last_dir_r;
    move_cnt_s   = move_cnt_r;
    err_s        = err_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (bus.cnt <= TARGET_CNT) begin
            state_s = SOLVED;
          end else begin
            state_s    = ISSUE;
            cand_idx_s = 7'd0;
            miss_cnt_s = 7'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        prev_cnt_s = bus.cnt;
        state_s    = CHECK;
      end
      CHECK: begin
        if (accept_s) begin
          move_valid_s = 1'b1;
          last_from_s  = cand_idx_r[6:2];
          last_dir_s   = cand_idx_r[1:0];
          move_cnt_s   = (move_cnt_r == 5'd31) ? 5'd31 : move_cnt_r + 5'd1;
          cand_idx_s   = 7'd0;
          miss_cnt_s   = 7'd0;
          state_s      = (bus.cnt == TARGET_CNT) ? SOLVED : ISSUE;
        end else if (reject_s) begin
          miss_cnt_s = miss_cnt_r + 7'd1;
          cand_idx_s = (cand_idx_r == NUM_CAND - 7'd1) ? 7'd0 : cand_idx_r + 7'd1;
          state_s    = ((miss_cnt_r + 7'd1) == NUM_CAND) ? STUCK : ISSUE;
        end else begin
          err_s   = 1'b1;
          state_s = STUCK;
        end
      end
      SOLVED: state_s = SOLVED;
      STUCK:  state_s = STUCK;
      default: state_s = IDLE;
    endcase
    from_s   = (state_s == ISSUE) ? cand_idx_s[6:2] : IDLE_FROM;
    dir_s    = cand_idx_s[1:0];
    busy_s   = (state_s == ISSUE) || (state_s == CHECK);
    solved_s = (state_s == SOLVED);
    stuck_s  = (state_s == STUCK);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cand_idx_r   <= 7'd0;
      miss_cnt_r   <= 7'd0;
      prev_cnt_r   <= 5'd0;
      from_r       <= IDLE_FROM;
      dir_r        <= 2'd0;
      move_valid_r <= 1'b0;
      last_from_r  <= 5'd0;
      last_dir_r   <= 2'd0;
      move_cnt_r   <= 5'd0;
      busy_r       <= 1'b0;
      solved_r     <= 1'b0;
      stuck_r      <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      cand_idx_r   <= cand_idx_s;
      miss_cnt_r   <= miss_cnt_s;
      prev_cnt_r   <= prev_cnt_s;
      from_r       <= from_s;
      dir_r        <= dir_s;
      move_valid_r <= move_valid_s;
      last_from_r  <= last_from_s;
      last_dir_r   <= last_dir_s;
      move_cnt_r   <= move_cnt_s;
      busy_r       <= busy_s;
      solved_r     <= solved_s;
      stuck_r      <= stuck_s;
      err_r        <= err_s;
    end
  end

  assign bus.from       = from_r;
  assign bus.dir        = dir_r;
  assign bus.move_valid = move_valid_r;
  assign bus.last_from  = last_from_r;
  assign bus.last_dir   = last_dir_r;
  assign bus.move_cnt   = move_cnt_r;
  assign bus.busy       = busy_r;
  assign bus.solved     = solved_r;
  assign bus.stuck      = stuck_r;
  assign bus.err        = err_r;
endmodule

// File: tb/tb_peg_move_sequencer.sv
// Scoreboard bench for peg_move_sequencer: a real 5x5 board model or a
// scripted peg-count stub feeds cnt; accepted moves are checked by a monitor.
module tb_peg_move_sequencer;
  logic clk = 1'b0;
  logic rst;

  peg_move_sequencer_if bus ();

  peg_move_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0] f;
    logic [1:0] d;
    logic [4:0] mc;
  } mv_t;
  mv_t exp_q[$];

  // Board model: holes row*5+col; U moves toward higher rows, L/R change column.
  logic [24:0] board;
  logic [24:0] board_init;
  logic        board_load;
  logic [4:0]  board_cnt;

  function automatic logic [24:0] apply_move(input logic [24:0] b, input logic [4:0] f,
                                             input logic [1:0] d);
    logic [24:0] nb;
    int r, c, dr, dc, mi, di, fi;
    nb = b;
    dr = 0;
    dc = 0;
    if (f < 5'd25) begin
      fi = int'(f);
      r  = fi / 5;
      c  = fi % 5;
      case (d)
        2'd0:    dr = 1;
        2'd1:    dr = -1;
        2'd2:    dc = -1;
        default: dc = 1;
      endcase
      if ((r + 2*dr >= 0) && (r + 2*dr < 5) && (c + 2*dc >= 0) && (c + 2*dc < 5)) begin
        mi = (r + dr) * 5 + c + dc;
        di = (r + 2*dr) * 5 + c + 2*dc;
        if (b[fi] && b[mi] && !b[di]) begin
          nb[fi] = 1'b0;
          nb[mi] = 1'b0;
          nb[di] = 1'b1;
        end
      end
    end
    return nb;
  endfunction

  always @(posedge clk) begin
    if (board_load) board <= board_init;
    else            board <= apply_move(board, bus.from, bus.dir);
  end

  always_comb board_cnt = 5'($countones(board));

  // Stub: drops by stub_drop on every stub_period-th offered move (0 = never).
  logic [4:0] stub_cnt;
  logic [4:0] stub_init;
  logic [4:0] stub_drop;
  int         stub_period;
  int         issue_n;
  logic       stub_load;
  logic       use_stub;

  always @(posedge clk) begin
    if (stub_load) begin
      stub_cnt <= stub_init;
      issue_n  <= 0;
    end else if ((bus.from < 5'd25) && (stub_period != 0)) begin
      if (issue_n + 1 == stub_period) begin
        issue_n  <= 0;
        stub_cnt <= stub_cnt - stub_drop;
      end else begin
        issue_n <= issue_n + 1;
      end
    end
  end

  assign bus.cnt = use_stub ? stub_cnt : board_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every move_valid pulse must match the next expected move.
  always @(negedge clk) begin
    mv_t e;
    if (bus.move_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_move: got from=%0d dir=%0d move_cnt=%0d, expected none",
                 bus.last_from, bus.last_dir, bus.move_cnt);
      end else begin
        e = exp_q.pop_front();
        check("move_last_from", 32'(bus.last_from), 32'(e.f));
        check("move_last_dir",  32'(bus.last_dir),  32'(e.d));
        check("move_cnt",       32'(bus.move_cnt),  32'(e.mc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.start  = 1'b0;
    rst        = 1'b1;
    board_load = 1'b1;
    stub_load  = 1'b1;
    tick();
    rst        = 1'b0;
    board_load = 1'b0;
    stub_load  = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_from"},       32'(bus.from),       32'd31);
    check({tag, "_dir"},        32'(bus.dir),        32'd0);
    check({tag, "_move_valid"}, 32'(bus.move_valid), 32'd0);
    check({tag, "_last_from"},  32'(bus.last_from),  32'd0);
    check({tag, "_last_dir"},   32'(bus.last_dir),   32'd0);
    check({tag, "_move_cnt"},   32'(bus.move_cnt),   32'd0);
    check({tag, "_busy"},       32'(bus.busy),       32'd0);
    check({tag, "_solved"},     32'(bus.solved),     32'd0);
    check({tag, "_stuck"},      32'(bus.stuck),      32'd0);
    check({tag, "_err"},        32'(bus.err),        32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst         = 1'b1;
    bus.start   = 1'b0;
    board_load  = 1'b1;
    stub_load   = 1'b1;
    use_stub    = 1'b1;
    stub_init   = 5'd5;
    stub_drop   = 5'd1;
    stub_period = 0;
    board_init  = 25'h1FF_FFFF;

    // Reset state.
    do_reset();
    check_reset_outputs("rst");

    // T1: real board, holes 12 and 24 empty; first hit is from 2 going U.
    use_stub   = 1'b0;
    board_init = 25'h1FF_FFFF & ~(25'd1 << 12) & ~(25'd1 << 24);
    do_reset();
    exp_q.push_back('{f: 5'd2, d: 2'd0, mc: 5'd1});
    pulse_start();
    cyc = 0;
    while (cyc < 40 && !bus.move_valid) begin
      tick();
      cyc++;
    end
    check("t1_latency", cyc, 18);
    tick();
    check("t1_busy_after_move", 32'(bus.busy), 32'd1);
    check("t1_queue_drained", exp_q.size(), 0);

    // T2: count never changes; a full fruitless sweep ends in STUCK.
    use_stub    = 1'b1;
    stub_init   = 5'd5;
    stub_period = 0;
    do_reset();
    pulse_start();
    cyc = 0;
    while (cyc < 300 && !bus.stuck) begin
      tick();
      cyc++;
    end
    check("t2_stuck_latency", cyc, 200);
    check("t2_busy", 32'(bus.busy), 32'd0);
    check("t2_err", 32'(bus.err), 32'd0);
    check("t2_solved", 32'(bus.solved), 32'd0);
    check("t2_from_idle", 32'(bus.from), 32'd31);

    // T3: count 3 drops on every 3rd offered move; solved at count 1.
    stub_init   = 5'd3;
    stub_period = 3;
    stub_drop   = 5'd1;
    do_reset();
    exp_q.push_back('{f: 5'd0, d: 2'd2, mc: 5'd1});
    exp_q.push_back('{f: 5'd0, d: 2'd2, mc: 5'd2});
    pulse_start();
    cyc = 0;
    while (cyc < 100 && !bus.solved) begin
      tick();
      cyc++;
    end
    check("t3_solve_latency", cyc, 12);
    check("t3_move_cnt", 32'(bus.move_cnt), 32'd2);
    check("t3_stuck", 32'(bus.stuck), 32'd0);
    check("t3_busy", 32'(bus.busy), 32'd0);
    pulse_start();
    repeat (4) tick();
    check("t3_from_idle", 32'(bus.from), 32'd31);
    check("t3_solved_held", 32'(bus.solved), 32'd1);
    check("t3_start_ignored_busy", 32'(bus.busy), 32'd0);
    check("t3_queue_drained", exp_q.size(), 0);

    // T4: count drops by two on the first move -> error, stuck, sticky.
    stub_init   = 5'd10;
    stub_period = 1;
    stub_drop   = 5'd2;
    do_reset();
    pulse_start();
    tick();
    check("t4_in_check_stuck", 32'(bus.stuck), 32'd0);
    tick();
    check("t4_err", 32'(bus.err), 32'd1);
    check("t4_stuck", 32'(bus.stuck), 32'd1);
    repeat (5) tick();
    check("t4_err_sticky", 32'(bus.err), 32'd1);
    do_reset();
    check("t4_err_cleared", 32'(bus.err), 32'd0);

    // T5: every move accepted; reset lands in CHECK after the fourth accept.
    stub_init   = 5'd20;
    stub_period = 1;
    stub_drop   = 5'd1;
    do_reset();
    for (int k = 1; k <= 4; k++) exp_q.push_back('{f: 5'd0, d: 2'd0, mc: 5'(k)});
    pulse_start();
    cyc = 0;
    while (cyc < 50 && bus.move_cnt != 5'd4) begin
      tick();
      cyc++;
    end
    check("t5_four_moves_latency", cyc, 8);
    tick();
    check("t5_busy_in_check", 32'(bus.busy), 32'd1);
    check("t5_from_idle_in_check", 32'(bus.from), 32'd31);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("t5");
    check("t5_queue_drained", exp_q.size(), 0);
    pulse_start();
    check("t5_restart_from", 32'(bus.from), 32'd0);
    check("t5_restart_dir", 32'(bus.dir), 32'd0);
    check("t5_restart_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // T6: already at target count when started.
    stub_init   = 5'd1;
    stub_period = 0;
    do_reset();
    pulse_start();
    check("t6_solved", 32'(bus.solved), 32'd1);
    check("t6_from", 32'(bus.from), 32'd31);
    check("t6_move_cnt", 32'(bus.move_cnt), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    check("t6_from_held", 32'(bus.from), 32'd31);
    check("t6_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
